// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the shared shift-add multiplier
// scheduler.
//   state_t      - sequencer states
//   MULT_N       - default operand width
//   cnt_width()  - width of the iteration counter for a given operand width
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADD,
        SHIFT,
        DONE
    } state_t;

    localparam int MULT_N = 4;

    // The counter has to hold the values 0..N-1, with one spare bit of headroom.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

    localparam int MULT_CNT_W = cnt_width(MULT_N);

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   i_clock/i_reset   - clock, synchronous active-high reset
//   i_req[1:0]        - eligible requesters
//   i_advance         - commit the finished grant to the pointer
//   i_adv_id          - id of the grant being committed
//   o_grant_valid     - at least one requester is eligible
//   o_grant_id        - winner; on a tie, the one not served last
module rr_arb2 (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    input  logic       i_adv_id,
    output logic       o_grant_valid,
    output logic       o_grant_id
);

    // Id of the most recently completed grant. Reset to 1 so that
    // requester 0 wins the first tie.
    logic r_last;

    always_ff @(posedge i_clock) begin
        if (i_reset)
            r_last <= 1'b1;
        else if (i_advance)
            r_last <= i_adv_id;
    end

    assign o_grant_valid = |i_req;
    assign o_grant_id    = (&i_req) ? ~r_last : i_req[1];

endmodule

// File: rtl/mult_scheduler.sv
// mult_scheduler: shares one external shift-add multiplier datapath between
// two requesters. It arbitrates round-robin, latches the winner's operands and
// sequences load/add/shift for N iterations. It then returns the 2N-bit
// product with a one-cycle done pulse.
//   i_clock, i_reset        - clock, synchronous active-high reset
//   i_req[1:0]              - level requests, held until the matching done
//   i_m0/i_q0, i_m1/i_q1    - multiplicand/multiplier per requester
//   i_dp_Q0, i_dp_AQ        - datapath Q LSB and A:Q contents
//   o_dp_M, o_dp_Qin        - latched operands to the datapath
//   o_dp_load/add/shift     - datapath controls (mutually exclusive)
//   o_busy, o_gnt_id        - activity flag, current/last grant id
//   o_result, o_done[1:0]   - last product, per-requester completion pulse
module mult_scheduler
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic [1:0]     i_req,
    input  logic [N-1:0]   i_m0,
    input  logic [N-1:0]   i_q0,
    input  logic [N-1:0]   i_m1,
    input  logic [N-1:0]   i_q1,
    input  logic           i_dp_Q0,
    input  logic [2*N-1:0] i_dp_AQ,
    output logic [N-1:0]   o_dp_M,
    output logic [N-1:0]   o_dp_Qin,
    output logic           o_dp_load,
    output logic           o_dp_add,
    output logic           o_dp_shift,
    output logic           o_busy,
    output logic           o_gnt_id,
    output logic [2*N-1:0] o_result,
    output logic [1:0]     o_done
);

    localparam int CW = cnt_width(N);

    state_t         r_state, w_next;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_op_m, r_op_q;
    logic           r_gnt;
    logic [2*N-1:0] r_result;
    logic [1:0]     r_done;

    logic [1:0]     w_elig;
    logic           w_gnt_valid, w_gnt_id;
    logic           w_last_iter;

    // A requester whose done is showing this cycle has not yet had a chance
    // to drop req, so it is masked to avoid serving it twice.
    assign w_elig      = i_req & ~r_done;
    assign w_last_iter = (r_cnt == CW'(N - 1));

    rr_arb2 u_arb (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_req         (w_elig),
        .i_advance     (r_state == DONE),
        .i_adv_id      (r_gnt),
        .o_grant_valid (w_gnt_valid),
        .o_grant_id    (w_gnt_id)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_op_m   <= '0;
            r_op_q   <= '0;
            r_gnt    <= 1'b0;
            r_result <= '0;
            r_done   <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_valid) begin
                        r_gnt  <= w_gnt_id;
                        r_op_m <= w_gnt_id ? i_m1 : i_m0;
                        r_op_q <= w_gnt_id ? i_q1 : i_q0;
                    end
                end
                LOAD:  r_cnt <= '0;
                SHIFT: r_cnt <= r_cnt + CW'(1);
                DONE: begin
                    r_result <= i_dp_AQ;
                    r_done   <= r_gnt ? 2'b10 : 2'b01;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_gnt_valid) w_next = LOAD;
            LOAD:    w_next = ADD;
            ADD:     w_next = SHIFT;
            SHIFT:   w_next = w_last_iter ? DONE : ADD;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign o_dp_M     = r_op_m;
    assign o_dp_Qin   = r_op_q;
    assign o_dp_load  = (r_state == LOAD);
    assign o_dp_add   = (r_state == ADD) & i_dp_Q0;
    assign o_dp_shift = (r_state == SHIFT);
    assign o_busy     = (r_state != IDLE);
    assign o_gnt_id   = r_gnt;
    assign o_result   = r_result;
    assign o_done     = r_done;

endmodule

// File: tb/tb_mult_scheduler.sv
module tb_mult_scheduler;

    localparam int N = 4;
    localparam int W = 2 * N;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           req0 = 1'b0, req1 = 1'b0;
    logic [N-1:0]   m0 = '0, q0 = '0, m1 = '0, q1 = '0;
    logic [N-1:0]   dp_M, dp_Qin;
    logic           dp_load, dp_add, dp_shift, busy, gnt_id;
    logic [W-1:0]   result;
    logic [1:0]     done;

    // behavioural shift-add datapath
    logic [N-1:0]   A = '0, Q = '0;
    logic           C = 1'b0;
    logic [W:0]     caq_shr;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    always #5 clk = ~clk;

    mult_scheduler #(.N(N)) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_req      ({req1, req0}),
        .i_m0       (m0),
        .i_q0       (q0),
        .i_m1       (m1),
        .i_q1       (q1),
        .i_dp_Q0    (Q[0]),
        .i_dp_AQ    ({A, Q}),
        .o_dp_M     (dp_M),
        .o_dp_Qin   (dp_Qin),
        .o_dp_load  (dp_load),
        .o_dp_add   (dp_add),
        .o_dp_shift (dp_shift),
        .o_busy     (busy),
        .o_gnt_id   (gnt_id),
        .o_result   (result),
        .o_done     (done)
    );

    assign caq_shr = {C, A, Q} >> 1;

    always @(posedge clk) begin
        if (dp_load) begin
            A <= '0; C <= 1'b0; Q <= dp_Qin;
        end else if (dp_add) begin
            {C, A} <= {1'b0, A} + {1'b0, dp_M};
        end else if (dp_shift) begin
            {C, A, Q} <= caq_shr;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] prod(input logic [N-1:0] m, input logic [N-1:0] q);
        return W'(m) * W'(q);
    endfunction

    // Present a new operation for requester id and record its expected product.
    task automatic set_op(input int id, input logic [N-1:0] m, input logic [N-1:0] q);
        if (id == 0) begin
            m0 = m; q0 = q; req0 = 1'b1; exp_q0.push_back(prod(m, q));
        end else begin
            m1 = m; q1 = q; req1 = 1'b1; exp_q1.push_back(prod(m, q));
        end
    endtask

    task automatic drop_req(input int id);
        if (id == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        chk("reset_outputs_zero",
            32'({dp_M, dp_Qin, dp_load, dp_add, dp_shift, busy, gnt_id, result, done}), 32'd0);
        rst = 1'b0;
    endtask

    // Single operation from an idle controller: checks load timing, the add
    // pattern (iteration k adds iff multiplier bit k-1 is set) and latency.
    task automatic run_single(input int id, input logic [N-1:0] m, input logic [N-1:0] q,
                              input bit change);
        bit seen = 0;
        @(negedge clk);
        set_op(id, m, q);
        for (int c = 1; c <= 30 && !seen; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("load_cycle1", 32'(dp_load), 32'd1);
                if (change) begin
                    if (id == 0) begin m0 = 2; q0 = 1; end else begin m1 = 2; q1 = 1; end
                end
            end
            if (c >= 2 && c <= 2 * N && (c % 2) == 0)
                chk($sformatf("add_iter%0d", c / 2), 32'(dp_add), 32'(q[c/2-1]));
            if (done != 2'b00) begin
                seen = 1;
                chk("done_latency", 32'(c), 32'(2 * N + 3));
                chk("done_bit", 32'(done), 32'(id == 0 ? 2 : 1) ^ 32'd3);
                chk("busy_low_at_done", 32'(busy), 32'd0);
                drop_req(id);
            end
        end
        if (!seen) chk("single_timeout", 32'd0, 32'd1);
    endtask

    // Random requester: issues nops operations, sometimes holding req through
    // done, dropping it after grant, or scrambling operands after grant.
    task automatic client(input int id, input int nops);
        bit holding = 0;
        for (int k = 0; k < nops; k++) begin
            bit granted = 0;
            bit got = 0;
            if (!holding) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                set_op(id, N'($urandom), N'($urandom));
            end
            for (int w = 0; w < 80 && !got; w++) begin
                @(negedge clk);
                if (!granted && dp_load && (gnt_id == id[0])) begin
                    granted = 1;
                    if ($urandom_range(0, 1) == 1) begin
                        if (id == 0) begin m0 = N'($urandom); q0 = N'($urandom); end
                        else begin m1 = N'($urandom); q1 = N'($urandom); end
                    end
                    if ($urandom_range(0, 3) == 0) drop_req(id);
                end
                if (done[id]) got = 1;
            end
            if (!got) chk($sformatf("client%0d_timeout", id), 32'd0, 32'd1);
            holding = (k < nops - 1) && ($urandom_range(0, 1) == 1);
            if (holding) set_op(id, N'($urandom), N'($urandom));
            else drop_req(id);
        end
    endtask

    // Monitor: pops the per-requester expectation whenever done shows.
    initial begin
        forever begin
            @(negedge clk);
            if (done != 2'b00) begin
                chk("done_onehot", 32'(done == 2'b11), 32'd0);
                if (done[0]) begin
                    if (exp_q0.size() == 0) chk("unexpected_done0", 32'd1, 32'd0);
                    else chk("result_req0", 32'(result), 32'(exp_q0.pop_front()));
                end
                if (done[1]) begin
                    if (exp_q1.size() == 0) chk("unexpected_done1", 32'd1, 32'd0);
                    else chk("result_req1", 32'(result), 32'(exp_q1.pop_front()));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit fin;
        do_reset();

        // basic product, zero multiplier, operand change after grant
        run_single(0, 4'd5, 4'd7, 0);
        run_single(0, 4'd9, 4'd0, 0);
        run_single(0, 4'd5, 4'd7, 1);

        // both requesting: 0 first, then 1, then 0 again, back to back
        do_reset();
        @(negedge clk);
        set_op(0, 4'd3, 4'd4);
        set_op(1, 4'd15, 4'd15);
        k = 0; fin = 0;
        for (int c = 1; c <= 60 && !fin; c++) begin
            @(negedge clk);
            if (done != 2'b00) begin
                k++;
                chk($sformatf("rr_done%0d_cycle", k), 32'(c), 32'(11 * k));
                chk($sformatf("rr_done%0d_id", k), 32'(done), (k == 2) ? 32'd2 : 32'd1);
                if (k == 1) set_op(0, 4'd6, 4'd7);
                if (k == 2) req1 = 1'b0;
                if (k == 3) begin req0 = 1'b0; fin = 1; end
            end
        end
        if (!fin) chk("rr_timeout", 32'd0, 32'd1);

        // reset in the SHIFT of iteration 2, then requester 1 alone
        @(negedge clk);
        set_op(0, 4'd5, 4'd3);
        repeat (5) @(negedge clk);
        chk("shift_iter2", 32'(dp_shift), 32'd1);
        exp_q0.delete();
        do_reset();
        run_single(1, 4'd6, 4'd9, 0);

        // req0 held through its own done: no grant in the done cycle
        run_single(0, 4'd2, 4'd3, 0);
        @(negedge clk);
        set_op(0, 4'd2, 4'd3);
        fin = 0;
        for (int c = 1; c <= 30 && !fin; c++) begin
            @(negedge clk);
            if (done[0]) begin fin = 1; set_op(0, 4'd7, 4'd5); end
        end
        if (!fin) chk("hold_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("no_regrant_in_done", 32'(dp_load), 32'd0);
        @(negedge clk);
        chk("regrant_next_cycle", 32'({dp_load, gnt_id}), 32'd2);
        fin = 0;
        for (int c = 1; c <= 30 && !fin; c++) begin
            @(negedge clk);
            if (done[0]) begin fin = 1; req0 = 1'b0; end
        end
        if (!fin) chk("hold2_timeout", 32'd0, 32'd1);

        // randomized traffic from both requesters
        fork
            client(0, 20);
            client(1, 20);
        join
        repeat (5) @(negedge clk);
        chk("queue0_drained", 32'(exp_q0.size()), 32'd0);
        chk("queue1_drained", 32'(exp_q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_scheduler.md
Name: mult_scheduler

Overview:
- Controller that shares one shift-add multiplier datapath (adder + A/Q register) between two requesters.
- Performs round-robin arbitration, latches the winner's operands and drives load/add/shift for N iterations.
- Captures the 2N-bit product and returns it with a one-cycle done pulse to the winning requester.
- Sits between client logic and the datapath, replacing a fixed single-user sequencer.

Parameters:
N, 4, operand width in bits; product width is 2N; iteration count is N.

Ports:
clock  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
req  in  2  level request, one bit per requester; held until that requester's done bit is seen
m0  in  N  multiplicand from requester 0
q0  in  N  multiplier from requester 0
m1  in  N  multiplicand from requester 1
q1  in  N  multiplier from requester 1
dp_Q0  in  1  LSB of the datapath Q register
dp_AQ  in  2N  datapath A:Q register contents
dp_M  out  N  multiplicand to the datapath adder (latched operand)
dp_Qin  out  N  multiplier value loaded into Q
dp_load  out  1  clear A/C and load Q from dp_Qin
dp_add  out  1  C,A <= A + M on this edge
dp_shift  out  1  shift C:A:Q right by one
busy  out  1  high in every state except IDLE
gnt_id  out  1  index of the current or most recent grant
result  out  2N  last completed product; held until the next completion
done  out  2  one-cycle pulse on the bit of the requester whose result is now valid

Behaviour:
- Reset (any state, including mid-operation) forces IDLE; drives every output to 0 and clears count.
- Reset sets the round-robin pointer so that requester 0 wins the first tie.
- States: IDLE, LOAD, ADD, SHIFT, DONE.
- IDLE:
  - eligible = req & ~done; a requester whose done bit is high this cycle is masked.
  - If none eligible, stay in IDLE.
  - If one is eligible, grant it.
  - If both are eligible, grant the one not granted last.
  - On the grant edge: register gnt_id, latch that requester's m/q into op_m/op_q, go to LOAD.
- LOAD (1 cycle): dp_load=1, dp_Qin=op_q, count<=0, next ADD.
- ADD (1 cycle): dp_add = dp_Q0, so an add is issued only when the Q LSB is 1; next SHIFT.
- SHIFT (1 cycle):
  - dp_shift=1, count<=count+1.
  - If count==N-1, go to DONE; else go to ADD.
- DONE (1 cycle): on the exit edge, result<=dp_AQ, done[gnt_id]<=1 for exactly one cycle, pointer updated, next IDLE.
- dp_M = op_m in all states. dp_load, dp_add and dp_shift are mutually exclusive and decoded from registered state.
- Latency: done and result valid 2N+3 cycles after the IDLE cycle in which req was sampled. For N=4 that is 11.
- Operands are sampled only on the grant edge; later changes on m/q have no effect on the operation in flight.
- A requester may drop req at any time after its grant; the operation still completes and done still pulses.
- Throughput: the next grant is taken in the cycle done is high (if the other requester is eligible), so operations run back to back with no idle gap.
- count width is clog2(N)+1. The product always fits in 2N bits; there is no overflow and no wrap.

Decomposition:
- Package mult_pkg:
  - state enum state_t {IDLE, LOAD, ADD, SHIFT, DONE};
  - default operand width constant MULT_N = 4;
  - localparam for the count width.
- One sub-module, rr_arb2:
  - 2-way round-robin arbiter with inputs req[1:0], advance, clock, reset;
  - outputs grant_valid and grant_id;
  - its pointer updates only when advance is asserted (DONE exit).

Test Plan:
- Reset, then req=01 with m0=5, q0=7 and a behavioural datapath model → dp_load in cycle 1; dp_add high in ADD iterations 1-3 and low in iteration 4; done=01 with result=8'h23 in cycle 11; busy low in cycle 11.
- req=11 held, with m0=3, q0=4 and m1=15, q1=15 → requester 0 served first (result 8'h0C), then requester 1 (result 8'hE1) with no idle gap; then requester 0 again; grants alternate.
- q0=0, m0=9 → no dp_add pulses; result=8'h00; done still pulses at cycle 11.
- Operand change mid-operation: m0 changed from 5 to 2 after LOAD → result still 8'h23.
- reset asserted in SHIFT of iteration 2 → next cycle all outputs 0 and state IDLE; a following req=10 gets the grant and completes correctly.
- req[0] held high through its own done cycle while req[1]=0 → not re-granted in the done cycle; re-granted in the following cycle only if still held.
